axi_stream_header_insert: RTL and testbench
===========================================

# axi_stream_header_insert

AXI-Stream header inserter: prepends a variable-length header (0 to DATA_BYTE_WIDTH bytes) to each packet and re-packs payload bytes so the output stream is contiguous. It sits directly downstream of the input skid_buffer stage, consuming its valid/data/keep/last/ready interface. It drives a registered AXI-Stream output at full throughput of one beat per cycle.

## Interface
- DATA_WIDTH, 32, stream width in bits, a multiple of 8
- DATA_BYTE_WIDTH, DATA_WIDTH/8, bytes per beat
- BYTE_CNT_WIDTH, $clog2(DATA_BYTE_WIDTH+1), header byte-count width
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- valid_in / data_in / keep_in / last_in  in  1/DATA_WIDTH/DATA_BYTE_WIDTH/1  payload from the skid buffer
- ready_out  out  1  payload accept (to skid buffer)
- valid_insert  in  1  header valid
- data_insert  in  DATA_WIDTH  header; valid bytes low-aligned
- keep_insert  in  DATA_BYTE_WIDTH  header keep, low-aligned contiguous (e.g. 4'b0011)
- byte_insert_cnt  in  BYTE_CNT_WIDTH  header byte count N, 0..DATA_BYTE_WIDTH
- ready_insert  out  1  header accept
- valid_out / data_out / keep_out / last_out  out  1/DATA_WIDTH/DATA_BYTE_WIDTH/1  packed output
- ready_in  in  1  downstream ready

## Operation
- Byte order: byte 0 is data[DATA_WIDTH-1 -: 8]. Payload keep_in is all ones except on the last beat, where it is high-aligned contiguous (k = popcount, 1..DATA_BYTE_WIDTH).
- N is taken from byte_insert_cnt. keep_insert is informational only.
- FSM:
  - IDLE: ready_insert=1, ready_out=0. A header handshake latches the N low bytes of data_insert into the residue register and stores N. Next state is PAYLOAD.
  - PAYLOAD: ready_insert=0. Each accepted beat loads data_out = {residue (N bytes), top DATA_BYTE_WIDTH-N bytes of data_in} with keep all ones. The residue becomes the low N bytes of data_in.
  - On the last beat with N+k <= DATA_BYTE_WIDTH: output keep = N+k high-aligned ones, last_out=1, next state IDLE.
  - On the last beat with N+k > DATA_BYTE_WIDTH: output a full non-last beat, next state TAIL with N+k-DATA_BYTE_WIDTH residue bytes.
  - TAIL: ready_out=0, ready_insert=0. Loads the residue high-aligned with matching keep and last_out=1, then next state IDLE.
- N=0 is pure pass-through. N=DATA_BYTE_WIDTH emits the header as a full beat and always ends in TAIL.
- Invalid byte lanes of data_out are 0.
- Payload presented while in IDLE is stalled; it is never dropped.

## Timing
- Output stage is a single register. It loads when (~valid_out | ready_in) and there is a beat to produce.
- ready_out = (state==PAYLOAD) & (~valid_out | ready_in). This is combinational from registers and ready_in.
- Latency: an input beat accepted at edge t is presented on valid_out from cycle t+1.
- Throughput: with ready_in held high, one output beat per cycle through PAYLOAD.
- Per-packet overhead: header accept takes 1 cycle (IDLE), plus 1 cycle in TAIL when the packet spills.
- The header handshake and a payload handshake never occur in the same cycle.
- valid_out and data_out are held stable while valid_out & ~ready_in.
- Reset (any cycle, including mid-packet):
  - State returns to IDLE; residue and N are discarded.
  - valid_out=0, last_out=0, keep_out=0, data_out=0.
  - ready_out=0. ready_insert=0 while rst=1, and 1 in the first cycle after release.

## Configuration
- HDR_INSERT_CHECK_EN defined: SVA assertions are compiled in. They check:
  - keep_insert equals N low-aligned ones.
  - keep_in is all ones on non-last beats and contiguous high-aligned on last beats.
  - data_out/valid_out are stable under backpressure.
  - No payload handshake occurs outside PAYLOAD.
- HDR_INSERT_CHECK_EN undefined: no assertions. RTL behaviour is identical.

## Test plan
- N=2, header 0x0000AABB, beats 0x11223344, 0x55667788 (last, keep 4'b1111), ready_in=1 -> outputs 0xAABB1122, 0x33445566, then 0x77880000 keep 4'b1100 last.
- N=3, header 0x00CCDDEE, single beat 0x99000000 keep 4'b1000 last -> one beat 0xCCDDEE99 keep 4'b1111 last; FSM skips TAIL.
- N=4, header 0x01020304, beat 0xA1A2A3A4 last keep 4'b1110 -> 0x01020304, then 0xA1A2A300 keep 4'b1110 last.
- N=0, 3-beat packet -> output byte-identical to input, one cycle latency, no bubbles.
- Random ready_in/valid_in toggling over 200 packets with random N and k -> output byte stream equals header‖payload per packet; no loss or duplication; outputs stable while stalled.
- rst pulsed mid-PAYLOAD after 1 of 3 beats -> next cycle valid_out=0 and ready_insert=1; a following N=1 packet is output correctly with no stale residue.

Source files
------------

// File: rtl/axi_stream_header_insert.sv
`default_nettype none
// ============================================================================
// Module      : axi_stream_header_insert
// Description : Prepends a 0..DATA_BYTE_WIDTH byte header to each AXI-Stream
//               packet and re-packs the payload into a contiguous stream.
//               Define HDR_INSERT_CHECK_EN to compile in interface assertions.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_stream_header_insert #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_BYTE_WIDTH = DATA_WIDTH / 8,
    parameter int BYTE_CNT_WIDTH  = $clog2(DATA_BYTE_WIDTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic [DATA_BYTE_WIDTH-1:0] keep_in,
    input  logic                       last_in,
    output logic                       ready_out,
    input  logic                       valid_insert,
    input  logic [DATA_WIDTH-1:0]      data_insert,
    input  logic [DATA_BYTE_WIDTH-1:0] keep_insert,
    input  logic [BYTE_CNT_WIDTH-1:0]  byte_insert_cnt,
    output logic                       ready_insert,
    output logic                       valid_out,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic [DATA_BYTE_WIDTH-1:0] keep_out,
    output logic                       last_out,
    input  logic                       ready_in
);

    localparam int C_SUM_WIDTH = BYTE_CNT_WIDTH + 1;
    localparam logic [C_SUM_WIDTH-1:0] C_NBYTES = C_SUM_WIDTH'(DATA_BYTE_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_TAIL    = 2'd2
    } state_t;

    state_t                      r_state;
    logic [DATA_WIDTH-1:0]       r_res;
    logic [BYTE_CNT_WIDTH-1:0]   r_n;
    logic [C_SUM_WIDTH-1:0]      r_tail;

    logic [DATA_WIDTH-1:0]       w_in_masked;
    logic [C_SUM_WIDTH-1:0]      w_k;
    logic [C_SUM_WIDTH-1:0]      w_sum;
    logic [C_SUM_WIDTH-1:0]      w_shb;
    logic [2*DATA_WIDTH-1:0]     w_cat;
    logic [DATA_WIDTH-1:0]       w_win;
    logic [DATA_WIDTH-1:0]       w_tail;
    logic [DATA_WIDTH-1:0]       w_hdr;
    logic                        w_adv;
    logic                        w_unused_keep_insert;

    function automatic logic [DATA_BYTE_WIDTH-1:0] f_keep_hi(input logic [C_SUM_WIDTH-1:0] cnt);
        f_keep_hi = ~({DATA_BYTE_WIDTH{1'b1}} >> cnt);
    endfunction

    // Invalid payload lanes are zeroed up front so every later window is clean.
    always_comb begin
        w_in_masked = '0;
        w_k         = '0;
        for (int i = 0; i < DATA_BYTE_WIDTH; i++) begin
            if (keep_in[i]) begin
                w_in_masked[i*8 +: 8] = data_in[i*8 +: 8];
                w_k                   = w_k + C_SUM_WIDTH'(1);
            end
        end
    end

    assign w_sum  = C_SUM_WIDTH'(r_n) + w_k;
    assign w_shb  = C_NBYTES - C_SUM_WIDTH'(r_n);
    assign w_adv  = ~valid_out | ready_in;
    assign w_cat  = {r_res, w_in_masked};
    assign w_win  = w_cat[{r_n, 3'b000} +: DATA_WIDTH];
    assign w_tail = r_res << {w_shb, 3'b000};
    assign w_hdr  = data_insert & ~({DATA_WIDTH{1'b1}} << {byte_insert_cnt, 3'b000});

    assign ready_insert = ~rst & (r_state == S_IDLE);
    assign ready_out    = ~rst & (r_state == S_PAYLOAD) & w_adv;

    assign w_unused_keep_insert = ^keep_insert;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_res     <= '0;
            r_n       <= '0;
            r_tail    <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
            keep_out  <= '0;
            last_out  <= 1'b0;
        end else begin
            if (valid_out && ready_in) begin
                valid_out <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (valid_insert) begin
                        r_res   <= w_hdr;
                        r_n     <= byte_insert_cnt;
                        r_state <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (valid_in && w_adv) begin
                        valid_out <= 1'b1;
                        data_out  <= w_win;
                        r_res     <= w_in_masked;
                        if (last_in && (w_sum <= C_NBYTES)) begin
                            keep_out <= f_keep_hi(w_sum);
                            last_out <= 1'b1;
                            r_state  <= S_IDLE;
                        end else begin
                            keep_out <= '1;
                            last_out <= 1'b0;
                            if (last_in) begin
                                r_tail  <= w_sum - C_NBYTES;
                                r_state <= S_TAIL;
                            end
                        end
                    end
                end
                S_TAIL: begin
                    if (w_adv) begin
                        valid_out <= 1'b1;
                        data_out  <= w_tail;
                        keep_out  <= f_keep_hi(r_tail);
                        last_out  <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef HDR_INSERT_CHECK_EN
    a_keep_insert: assert property (@(posedge clk) disable iff (rst)
        (valid_insert && ready_insert) |->
            (keep_insert == ~({DATA_BYTE_WIDTH{1'b1}} << byte_insert_cnt)));

    a_keep_mid: assert property (@(posedge clk) disable iff (rst)
        (valid_in && ready_out && !last_in) |-> (&keep_in));

    a_keep_last: assert property (@(posedge clk) disable iff (rst)
        (valid_in && ready_out && last_in) |-> ((w_k != '0) && (keep_in == f_keep_hi(w_k))));

    a_out_stable: assert property (@(posedge clk) disable iff (rst)
        (valid_out && !ready_in) |=> (valid_out && $stable(data_out)));

    a_no_stray_payload: assert property (@(posedge clk) disable iff (rst)
        (valid_in && ready_out) |-> (r_state == S_PAYLOAD));
`else
    // Interface checks compiled out.
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_stream_header_insert.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_stream_header_insert
// Description : Self-checking bench: vector table, reset sequences and random
//               traffic compared against a byte-stream reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_stream_header_insert;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [31:0] data_in = '0;
    logic [3:0]  keep_in = '0;
    logic        last_in = 1'b0;
    logic        ready_out;
    logic        valid_insert = 1'b0;
    logic [31:0] data_insert = '0;
    logic [3:0]  keep_insert = '0;
    logic [2:0]  byte_insert_cnt = '0;
    logic        ready_insert;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        ready_in = 1'b0;

    always #5 clk = ~clk;

    axi_stream_header_insert dut (
        .clk(clk), .rst(rst),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
        .ready_out(ready_out),
        .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
        .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
        .ready_in(ready_in)
    );

    typedef struct {
        int               n;
        logic [31:0]      hdr;
        int               len;
        logic [3:0][31:0] d;
        logic [3:0]       klast;
    } pkt_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        int          cyc;
    } beat_t;

    typedef struct {
        int               n;
        logic [31:0]      hdr;
        int               len;
        logic [3:0][31:0] d;
        logic [3:0]       klast;
        int               nexp;
        logic [3:0][31:0] ed;
        logic [3:0][3:0]  ek;
    } vec_t;

    pkt_t  pkts[$];
    beat_t exp_q[$];
    beat_t obs[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    acc_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: flatten header then payload into bytes, cut into output beats.
    task automatic build_exp(input pkt_t p);
        logic [7:0] bq[$];
        beat_t b;
        for (int i = 0; i < p.n; i++) bq.push_back(p.hdr[(p.n-1-i)*8 +: 8]);
        for (int j = 0; j < p.len; j++) begin
            int nb;
            nb = (j == p.len - 1) ? $countones(p.klast) : 4;
            for (int s = 0; s < nb; s++) bq.push_back(p.d[j][(3-s)*8 +: 8]);
        end
        while (bq.size() > 0) begin
            b = '{data: '0, keep: '0, last: 1'b0, cyc: 0};
            for (int s = 0; s < 4; s++) begin
                if (bq.size() > 0) begin
                    b.data[(3-s)*8 +: 8] = bq.pop_front();
                    b.keep[3-s] = 1'b1;
                end
            end
            b.last = (bq.size() == 0);
            exp_q.push_back(b);
        end
    endtask

    task automatic run_traffic(input int p_in, input int p_hdr, input int p_rdy, input int max_cyc);
        int hi = 0, pi = 0, bi = 0, cyc = 0;
        int np;
        bit stall = 0, hs_h, hs_p, hs_o;
        logic [31:0] sdata;
        logic [3:0]  skeep, full;
        beat_t e;
        np = pkts.size();
        full = 4'hF;
        obs.delete();
        acc_cyc = -1;
        while ((exp_q.size() > 0 || hi < np || pi < np) && cyc < max_cyc) begin
            if (!valid_insert && hi < np && $urandom_range(0, 99) < p_hdr) begin
                valid_insert    = 1'b1;
                data_insert     = pkts[hi].hdr;
                byte_insert_cnt = 3'(pkts[hi].n);
                keep_insert     = full >> (4 - pkts[hi].n);
            end
            if (!valid_in && pi < np && $urandom_range(0, 99) < p_in) begin
                valid_in = 1'b1;
                data_in  = pkts[pi].d[bi];
                last_in  = (bi == pkts[pi].len - 1);
                keep_in  = last_in ? pkts[pi].klast : 4'hF;
            end
            ready_in = ($urandom_range(0, 99) < p_rdy);
            @(negedge clk);
            hs_h = valid_insert & ready_insert;
            hs_p = valid_in & ready_out;
            hs_o = valid_out & ready_in;
            chk("excl_ready", 64'(ready_insert & ready_out), 64'd0);
            if (stall) begin
                chk("hold_valid", 64'(valid_out), 64'd1);
                chk("hold_data", 64'(data_out), 64'(sdata));
                chk("hold_keep", 64'(keep_out), 64'(skeep));
            end
            if (hs_p && acc_cyc < 0) acc_cyc = cyc;
            if (hs_o) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_beat: got data %h with nothing expected", data_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 64'(data_out), 64'(e.data));
                    chk("out_keep", 64'(keep_out), 64'(e.keep));
                    chk("out_last", 64'(last_out), 64'(e.last));
                end
                obs.push_back('{data: data_out, keep: keep_out, last: last_out, cyc: cyc});
            end
            stall = valid_out & ~ready_in;
            sdata = data_out;
            skeep = keep_out;
            @(posedge clk);
            #1;
            cyc++;
            if (hs_h) begin
                hi++;
                valid_insert = 1'b0;
            end
            if (hs_p) begin
                valid_in = 1'b0;
                bi++;
                if (bi == pkts[pi].len) begin
                    pi++;
                    bi = 0;
                end
            end
        end
        if (cyc >= max_cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got %0d beats pending expected 0", exp_q.size());
        end
        valid_in     = 1'b0;
        valid_insert = 1'b0;
        ready_in     = 1'b0;
        pkts.delete();
        exp_q.delete();
    endtask

    vec_t vt[4];

    initial begin
        pkt_t p;
        logic [3:0] full;
        full = 4'hF;

        vt[0] = '{n: 2, hdr: 32'h0000AABB, len: 2,
                  d: {32'h0, 32'h0, 32'h55667788, 32'h11223344}, klast: 4'hF, nexp: 3,
                  ed: {32'h0, 32'h77880000, 32'h33445566, 32'hAABB1122},
                  ek: {4'h0, 4'hC, 4'hF, 4'hF}};
        vt[1] = '{n: 3, hdr: 32'h00CCDDEE, len: 1,
                  d: {32'h0, 32'h0, 32'h0, 32'h99000000}, klast: 4'h8, nexp: 1,
                  ed: {32'h0, 32'h0, 32'h0, 32'hCCDDEE99},
                  ek: {4'h0, 4'h0, 4'h0, 4'hF}};
        vt[2] = '{n: 4, hdr: 32'h01020304, len: 1,
                  d: {32'h0, 32'h0, 32'h0, 32'hA1A2A3A4}, klast: 4'hE, nexp: 2,
                  ed: {32'h0, 32'h0, 32'hA1A2A300, 32'h01020304},
                  ek: {4'h0, 4'h0, 4'hE, 4'hF}};
        vt[3] = '{n: 0, hdr: 32'h0, len: 3,
                  d: {32'h0, 32'h090A0000, 32'h05060708, 32'h01020304}, klast: 4'hC, nexp: 3,
                  ed: {32'h0, 32'h090A0000, 32'h05060708, 32'h01020304},
                  ek: {4'h0, 4'hC, 4'hF, 4'hF}};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_valid_out", 64'(valid_out), 64'd0);
        chk("rst_data_out", 64'(data_out), 64'd0);
        chk("rst_keep_out", 64'(keep_out), 64'd0);
        chk("rst_last_out", 64'(last_out), 64'd0);
        chk("rst_ready_out", 64'(ready_out), 64'd0);
        chk("rst_ready_insert", 64'(ready_insert), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready_insert", 64'(ready_insert), 64'd1);
        @(posedge clk);
        #1;

        // Directed vectors at full throughput
        for (int i = 0; i < 4; i++) begin
            p = '{n: vt[i].n, hdr: vt[i].hdr, len: vt[i].len, d: vt[i].d, klast: vt[i].klast};
            pkts.push_back(p);
            build_exp(p);
            run_traffic(100, 100, 100, 200);
            chk($sformatf("v%0d_count", i), 64'(obs.size()), 64'(vt[i].nexp));
            for (int j = 0; j < obs.size() && j < vt[i].nexp; j++) begin
                chk($sformatf("v%0d_data%0d", i, j), 64'(obs[j].data), 64'(vt[i].ed[j]));
                chk($sformatf("v%0d_keep%0d", i, j), 64'(obs[j].keep), 64'(vt[i].ek[j]));
                chk($sformatf("v%0d_last%0d", i, j), 64'(obs[j].last), 64'(j == vt[i].nexp - 1));
                if (j == 0) chk($sformatf("v%0d_latency", i), 64'(obs[0].cyc - acc_cyc), 64'd1);
                else chk($sformatf("v%0d_gap%0d", i, j), 64'(obs[j].cyc - obs[j-1].cyc), 64'd1);
            end
        end

        // Random traffic with backpressure
        for (int i = 0; i < 200; i++) begin
            int k;
            p.n   = $urandom_range(0, 4);
            p.hdr = $urandom;
            p.len = $urandom_range(1, 4);
            for (int j = 0; j < 4; j++) p.d[j] = $urandom;
            k = $urandom_range(1, 4);
            p.klast = full << (4 - k);
            pkts.push_back(p);
            build_exp(p);
        end
        run_traffic(70, 70, 60, 20000);

        // Reset mid-PAYLOAD, then a clean N=1 packet
        valid_insert    = 1'b1;
        data_insert     = 32'h0000_1234;
        byte_insert_cnt = 3'd2;
        keep_insert     = 4'h3;
        ready_in        = 1'b1;
        @(posedge clk);
        #1;
        valid_insert = 1'b0;
        valid_in     = 1'b1;
        data_in      = 32'hDEADBEEF;
        keep_in      = 4'hF;
        last_in      = 1'b0;
        @(negedge clk);
        chk("mid_ready_out", 64'(ready_out), 64'd1);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready_insert", 64'(ready_insert), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid_out", 64'(valid_out), 64'd0);
        chk("post_rst_data_out", 64'(data_out), 64'd0);
        chk("post_rst_keep_out", 64'(keep_out), 64'd0);
        chk("post_rst_ready_insert", 64'(ready_insert), 64'd1);
        chk("post_rst_ready_out", 64'(ready_out), 64'd0);
        @(posedge clk);
        #1;
        p = '{n: 1, hdr: 32'h000000C5, len: 2,
              d: {32'h0, 32'h0, 32'h44556677, 32'h00112233}, klast: 4'hE};
        pkts.push_back(p);
        build_exp(p);
        run_traffic(100, 100, 100, 200);
        chk("post_rst_pkt_beats", 64'(obs.size()), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
